// File: rtl/dsa_pkg.sv
// Shared constants for the systolic array edge stages (skew / deskew).
package dsa_pkg;

    localparam int unsigned RESULT_W = 32;
    localparam int unsigned ARRAY_N  = 16;

    // Register stages a lane needs so that all lanes of a row line up with the last lane.
    function automatic int unsigned lane_delay(input int unsigned lane, input int unsigned num);
        return num - 1 - lane;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read, synchronous flush and occupancy output.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_pop;
    logic             do_push;

    assign level_o = LVL_W'(wr_ptr_q - rd_ptr_q);
    assign full_o  = (level_o == LVL_W'(DEPTH));
    assign empty_o = (level_o == '0);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer next state; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/result_deskew.sv
// Realigns skewed result lanes from the PE grid into whole rows and buffers them for writeback.
module result_deskew
    import dsa_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RESULT_W,
    parameter int unsigned DATA_NUM   = ARRAY_N,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [DATA_NUM-1:0][DATA_WIDTH-1:0]  data_in,
    input  logic                                 input_valid_i,
    input  logic                                 calc_done_i,
    input  logic                                 clear_i,
    output logic [DATA_NUM-1:0][DATA_WIDTH-1:0]  data_out,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic                                 out_last_o,
    output logic                                 done_o,
    output logic                                 overflow_o,
    output logic [CNT_WIDTH-1:0]                 row_count_o,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_level_o
);

    localparam int unsigned ROW_W = DATA_WIDTH * DATA_NUM;
    localparam int unsigned ENT_W = ROW_W + 1;

    logic [DATA_NUM-1:0][DATA_WIDTH-1:0] aligned_row;
    logic                                aligned_vld;
    logic                                aligned_last;
    logic [DATA_NUM-1:0][DATA_WIDTH-1:0] head_row;
    logic                                head_last;
    logic                                fifo_full;
    logic                                fifo_empty;
    logic                                push;
    logic                                pop;

    logic                 overflow_q, overflow_d;
    logic                 done_q, done_d;
    logic [CNT_WIDTH-1:0] row_count_q, row_count_d;

    // Per-lane delay lines: lane i waits DATA_NUM-1-i cycles to meet the last lane.
    for (genvar i = 0; i < DATA_NUM; i++) begin : g_lane
        localparam int unsigned D = lane_delay(i, DATA_NUM);
        if (D == 0) begin : g_pass
            assign aligned_row[i] = data_in[i];
        end else begin : g_dly
            logic [DATA_WIDTH-1:0] dly_q [D];
            // Data shift register; validity is tracked by the control chain.
            always_ff @(posedge clk) begin
                dly_q[0] <= data_in[i];
                for (int k = 1; k < int'(D); k++) dly_q[k] <= dly_q[k-1];
            end
            assign aligned_row[i] = dly_q[D-1];
        end
    end

    // Valid/last travel with lane 0, so they see the full DATA_NUM-1 delay.
    if (DATA_NUM == 1) begin : g_ctl_pass
        assign aligned_vld  = input_valid_i;
        assign aligned_last = input_valid_i && calc_done_i;
    end else begin : g_ctl_dly
        localparam int unsigned CHN = DATA_NUM - 1;
        logic [CHN-1:0] vld_q;
        logic [CHN-1:0] last_q;
        // Control delay chain; flushing it discards rows still in flight.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q  <= '0;
                last_q <= '0;
            end else if (clear_i) begin
                vld_q  <= '0;
                last_q <= '0;
            end else begin
                vld_q  <= (vld_q << 1)  | CHN'(input_valid_i);
                last_q <= (last_q << 1) | CHN'(input_valid_i && calc_done_i);
            end
        end
        assign aligned_vld  = vld_q[CHN-1];
        assign aligned_last = last_q[CHN-1];
    end

    assign push = aligned_vld && !clear_i;
    assign pop  = out_valid_o && out_ready_i;

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({aligned_last, aligned_row}),
        .rdata_o ({head_last, head_row}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    assign out_valid_o = !fifo_empty;
    assign out_last_o  = !fifo_empty && head_last;
    assign data_out    = head_row;

    // Status next state: sticky overflow, popped-row counter, end-of-tile pulse.
    always_comb begin
        overflow_d  = overflow_q;
        row_count_d = row_count_q;
        done_d      = 1'b0;
        if (clear_i) begin
            overflow_d  = 1'b0;
            row_count_d = '0;
        end else begin
            if (push && fifo_full && !pop) overflow_d = 1'b1;
            if (pop) begin
                row_count_d = row_count_q + CNT_WIDTH'(1);
                done_d      = head_last;
            end
        end
    end

    // Status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            row_count_q <= '0;
            done_q      <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            row_count_q <= row_count_d;
            done_q      <= done_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign row_count_o = row_count_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_result_deskew.sv
// Directed bench for result_deskew: 4-lane instance driven from a vector table, plus a 1-lane instance.
module tb_result_deskew;

    logic clk;
    logic rst_n;

    // 4-lane instance
    logic [3:0][31:0] d4_in, d4_out;
    logic             d4_vin, d4_lin, d4_clr, d4_rdy;
    logic             d4_vld, d4_last, d4_done, d4_ovf;
    logic [15:0]      d4_cnt;
    logic [2:0]       d4_lvl;

    // 1-lane instance
    logic [0:0][31:0] d1_in, d1_out;
    logic             d1_vin, d1_lin, d1_clr, d1_rdy;
    logic             d1_vld, d1_last, d1_done, d1_ovf;
    logic [15:0]      d1_cnt;
    logic [2:0]       d1_lvl;

    result_deskew #(.DATA_WIDTH(32), .DATA_NUM(4), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .data_in(d4_in), .input_valid_i(d4_vin),
        .calc_done_i(d4_lin), .clear_i(d4_clr), .data_out(d4_out), .out_valid_o(d4_vld),
        .out_ready_i(d4_rdy), .out_last_o(d4_last), .done_o(d4_done), .overflow_o(d4_ovf),
        .row_count_o(d4_cnt), .fifo_level_o(d4_lvl)
    );

    result_deskew #(.DATA_WIDTH(32), .DATA_NUM(1), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(d1_in), .input_valid_i(d1_vin),
        .calc_done_i(d1_lin), .clear_i(d1_clr), .data_out(d1_out), .out_valid_o(d1_vld),
        .out_ready_i(d1_rdy), .out_last_o(d1_last), .done_o(d1_done), .overflow_o(d1_ovf),
        .row_count_o(d1_cnt), .fifo_level_o(d1_lvl)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        bit    vin, lin, rdy, clr;
        int    rid;
        bit    e_vld, e_last, e_done, e_ovf;
        int    e_rid, e_lvl, e_cnt;
    } vec_t;

    vec_t vq[$];
    int   hist[4];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(string tag, bit vin, bit lin, int rid, bit rdy, bit clr,
                                bit e_vld, int e_rid, bit e_last, int e_lvl, int e_cnt,
                                bit e_done, bit e_ovf);
        vec_t v;
        v.tag = tag; v.vin = vin; v.lin = lin; v.rid = rid; v.rdy = rdy; v.clr = clr;
        v.e_vld = e_vld; v.e_rid = e_rid; v.e_last = e_last; v.e_lvl = e_lvl;
        v.e_cnt = e_cnt; v.e_done = e_done; v.e_ovf = e_ovf;
        return v;
    endfunction

    function automatic logic [3:0][31:0] exp_row(int r);
        logic [3:0][31:0] v;
        for (int i = 0; i < 4; i++) v[i] = 32'(16 * r + i);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Drive one cycle of skewed input: lane i carries the row launched i cycles earlier.
    task automatic drive4(input bit vin, input bit lin, input int rid, input bit rdy, input bit clr);
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = vin ? rid : -1;
        for (int i = 0; i < 4; i++)
            d4_in[i] = (hist[i] >= 0) ? 32'(16 * hist[i] + i) : (32'hBAD0_0000 | 32'(i));
        d4_vin = vin;
        d4_lin = lin;
        d4_rdy = rdy;
        d4_clr = clr;
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        d4_in = '0; d4_vin = 0; d4_lin = 0; d4_clr = 0; d4_rdy = 0;
        d1_in = '0; d1_vin = 0; d1_lin = 0; d1_clr = 0; d1_rdy = 0;
        for (int i = 0; i < 4; i++) hist[i] = -1;

        // Alignment: 3 rows, ready high, then clear.
        vq.push_back(mk("align", 1,0,0, 1,0, 0,0,0,0,0,0,0));
        vq.push_back(mk("align", 1,0,1, 1,0, 0,0,0,0,0,0,0));
        vq.push_back(mk("align", 1,0,2, 1,0, 0,0,0,0,0,0,0));
        vq.push_back(mk("align", 0,0,0, 1,0, 0,0,0,0,0,0,0));
        vq.push_back(mk("align", 0,0,0, 1,0, 1,0,0,1,0,0,0));
        vq.push_back(mk("align", 0,0,0, 1,0, 1,1,0,1,1,0,0));
        vq.push_back(mk("align", 0,0,0, 1,0, 1,2,0,1,2,0,0));
        vq.push_back(mk("align", 0,0,0, 1,0, 0,0,0,0,3,0,0));
        vq.push_back(mk("align", 0,0,0, 1,1, 0,0,0,0,3,0,0));
        // Tile end: 5 rows, last on row 4.
        vq.push_back(mk("tile", 1,0,0, 1,0, 0,0,0,0,0,0,0));
        vq.push_back(mk("tile", 1,0,1, 1,0, 0,0,0,0,0,0,0));
        vq.push_back(mk("tile", 1,0,2, 1,0, 0,0,0,0,0,0,0));
        vq.push_back(mk("tile", 1,0,3, 1,0, 0,0,0,0,0,0,0));
        vq.push_back(mk("tile", 1,1,4, 1,0, 1,0,0,1,0,0,0));
        vq.push_back(mk("tile", 0,0,0, 1,0, 1,1,0,1,1,0,0));
        vq.push_back(mk("tile", 0,0,0, 1,0, 1,2,0,1,2,0,0));
        vq.push_back(mk("tile", 0,0,0, 1,0, 1,3,0,1,3,0,0));
        vq.push_back(mk("tile", 0,0,0, 1,0, 1,4,1,1,4,0,0));
        vq.push_back(mk("tile", 0,0,0, 1,0, 0,0,0,0,5,1,0));
        vq.push_back(mk("tile", 0,0,0, 1,1, 0,0,0,0,5,0,0));
        // Backpressure and overflow: 6 rows into a 4-deep FIFO, then drain.
        vq.push_back(mk("ovf", 1,0,0, 0,0, 0,0,0,0,0,0,0));
        vq.push_back(mk("ovf", 1,0,1, 0,0, 0,0,0,0,0,0,0));
        vq.push_back(mk("ovf", 1,0,2, 0,0, 0,0,0,0,0,0,0));
        vq.push_back(mk("ovf", 1,0,3, 0,0, 0,0,0,0,0,0,0));
        vq.push_back(mk("ovf", 1,0,4, 0,0, 1,0,0,1,0,0,0));
        vq.push_back(mk("ovf", 1,0,5, 0,0, 1,0,0,2,0,0,0));
        vq.push_back(mk("ovf", 0,0,0, 0,0, 1,0,0,3,0,0,0));
        vq.push_back(mk("ovf", 0,0,0, 0,0, 1,0,0,4,0,0,0));
        vq.push_back(mk("ovf", 0,0,0, 0,0, 1,0,0,4,0,0,1));
        vq.push_back(mk("ovf", 0,0,0, 1,0, 1,0,0,4,0,0,1));
        vq.push_back(mk("ovf", 0,0,0, 1,0, 1,1,0,3,1,0,1));
        vq.push_back(mk("ovf", 0,0,0, 1,0, 1,2,0,2,2,0,1));
        vq.push_back(mk("ovf", 0,0,0, 1,0, 1,3,0,1,3,0,1));
        vq.push_back(mk("ovf", 0,0,0, 1,1, 0,0,0,0,4,0,1));
        // Full FIFO with simultaneous push and pop for 8 cycles.
        for (int c = 0; c < 20; c++) begin
            int lvl;
            lvl = (c < 4) ? 0 : (c <= 7) ? c - 3 : (c <= 15) ? 4 : 19 - c;
            vq.push_back(mk("full", c <= 11, 0, c, c >= 7, 0,
                            (c >= 4) && (c <= 18), (c < 7) ? 0 : c - 7, 0, lvl,
                            (c < 7) ? 0 : c - 7, 0, 0));
        end
        vq.push_back(mk("full", 0,0,0, 1,1, 0,0,0,0,12,0,0));
        // Clear with 2 rows buffered, 2 in flight and a row presented in the clear cycle.
        vq.push_back(mk("clr", 1,0,0, 0,0, 0,0,0,0,0,0,0));
        vq.push_back(mk("clr", 1,0,1, 0,0, 0,0,0,0,0,0,0));
        vq.push_back(mk("clr", 1,0,2, 0,0, 0,0,0,0,0,0,0));
        vq.push_back(mk("clr", 1,0,3, 0,0, 0,0,0,0,0,0,0));
        vq.push_back(mk("clr", 0,0,0, 0,0, 1,0,0,1,0,0,0));
        vq.push_back(mk("clr", 1,1,4, 0,1, 1,0,0,2,0,0,0));
        for (int c = 6; c <= 10; c++) vq.push_back(mk("clr", 0,0,0, 1,0, 0,0,0,0,0,0,0));
        vq.push_back(mk("clr", 1,0,8, 1,0, 0,0,0,0,0,0,0));
        vq.push_back(mk("clr", 1,0,9, 1,0, 0,0,0,0,0,0,0));
        vq.push_back(mk("clr", 0,0,0, 1,0, 0,0,0,0,0,0,0));
        vq.push_back(mk("clr", 0,0,0, 1,0, 0,0,0,0,0,0,0));
        vq.push_back(mk("clr", 0,0,0, 1,0, 1,8,0,1,0,0,0));
        vq.push_back(mk("clr", 0,0,0, 1,0, 1,9,0,1,1,0,0));
        vq.push_back(mk("clr", 0,0,0, 1,0, 0,0,0,0,2,0,0));

        // Reset state
        @(negedge clk);
        chk("rst valid",    128'(d4_vld),  128'(0));
        chk("rst last",     128'(d4_last), 128'(0));
        chk("rst level",    128'(d4_lvl),  128'(0));
        chk("rst count",    128'(d4_cnt),  128'(0));
        chk("rst overflow", 128'(d4_ovf),  128'(0));
        chk("rst done",     128'(d4_done), 128'(0));
        chk("rst1 valid",   128'(d1_vld),  128'(0));
        rst_n = 1'b1;

        foreach (vq[k]) begin
            string p;
            p = $sformatf("%s[%0d]", vq[k].tag, k);
            chk({p, " valid"},    128'(d4_vld),  128'(vq[k].e_vld));
            chk({p, " level"},    128'(d4_lvl),  128'(vq[k].e_lvl));
            chk({p, " count"},    128'(d4_cnt),  128'(vq[k].e_cnt));
            chk({p, " done"},     128'(d4_done), 128'(vq[k].e_done));
            chk({p, " overflow"}, 128'(d4_ovf),  128'(vq[k].e_ovf));
            if (vq[k].e_vld) begin
                chk({p, " data"}, 128'(d4_out), 128'(exp_row(vq[k].e_rid)));
                chk({p, " last"}, 128'(d4_last), 128'(vq[k].e_last));
            end
            drive4(vq[k].vin, vq[k].lin, vq[k].rid, vq[k].rdy, vq[k].clr);
            @(negedge clk);
        end

        // Async reset mid-cycle with two rows buffered and counter non-zero.
        drive4(1, 0, 10, 0, 0); @(negedge clk);
        drive4(1, 0, 11, 0, 0); @(negedge clk);
        for (int c = 0; c < 4; c++) begin drive4(0, 0, 0, 0, 0); @(negedge clk); end
        chk("prereset level", 128'(d4_lvl), 128'(2));
        chk("prereset count", 128'(d4_cnt), 128'(2));
        #2 rst_n = 1'b0;
        #1;
        chk("async valid", 128'(d4_vld), 128'(0));
        chk("async level", 128'(d4_lvl), 128'(0));
        chk("async count", 128'(d4_cnt), 128'(0));
        chk("async last",  128'(d4_last), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive4(0, 0, 0, 1, 0);
            @(negedge clk);
            chk($sformatf("postreset[%0d] valid", c), 128'(d4_vld), 128'(0));
            chk($sformatf("postreset[%0d] done", c),  128'(d4_done), 128'(0));
        end

        // Single-lane instance: one-cycle latency, no skew.
        chk("n1 idle valid", 128'(d1_vld), 128'(0));
        d1_in[0] = 32'hCAFE_0001; d1_vin = 1; d1_lin = 1; d1_rdy = 1;
        @(negedge clk);
        chk("n1 valid", 128'(d1_vld),  128'(1));
        chk("n1 data",  128'(d1_out),  128'(32'hCAFE_0001));
        chk("n1 last",  128'(d1_last), 128'(1));
        chk("n1 level", 128'(d1_lvl),  128'(1));
        d1_vin = 0; d1_lin = 0; d1_in[0] = 32'h0;
        @(negedge clk);
        chk("n1 drained", 128'(d1_vld),  128'(0));
        chk("n1 done",    128'(d1_done), 128'(1));
        chk("n1 count",   128'(d1_cnt),  128'(1));
        chk("n1 ovf",     128'(d1_ovf),  128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/result_deskew.md
Name: result_deskew

Overview:
- Sits on the bottom edge of the systolic array, after the PE grid.
- Re-aligns the skewed result lanes into whole rows. Lane i of a row arrives i cycles after lane 0.
- Buffers aligned rows in a small FIFO and presents them on a valid/ready interface to the writeback path.
- Companion to the input skew stage: the array cannot stall, so this block absorbs short downstream backpressure and flags overflow.

Parameters:
- DATA_WIDTH, 32, bit width of one result lane.
- DATA_NUM, 16, number of lanes (array columns); must be >= 1.
- FIFO_DEPTH, 4, aligned-row buffer entries; power of two, >= 2.
- CNT_WIDTH, 16, width of the emitted-row counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  DATA_WIDTH x DATA_NUM  skewed lane data; lane i valid i cycles after lane 0.
- input_valid_i  input  1  row valid, timed with lane 0.
- calc_done_i  input  1  marks last row of a tile, timed with lane 0; ignored unless input_valid_i.
- clear_i  input  1  synchronous flush.
- data_out  output  DATA_WIDTH x DATA_NUM  aligned row at FIFO head.
- out_valid_o  output  1  head row valid.
- out_ready_i  input  1  downstream accepts head row.
- out_last_o  output  1  head row is last row of tile.
- done_o  output  1  one-cycle pulse when the last row is accepted.
- overflow_o  output  1  sticky: an aligned row was dropped.
- row_count_o  output  CNT_WIDTH  rows accepted downstream since reset/clear; wraps.
- fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low, async):
  - Clears the control delay chain, FIFO pointers and level, overflow_o, row_count_o and done_o.
  - out_valid_o, out_last_o = 0.
  - data_out is don't-care while out_valid_o = 0. Lane data registers need no reset.
- Deskew:
  - Lane i is delayed by DATA_NUM-1-i register stages. Lane DATA_NUM-1 passes with zero delay.
  - input_valid_i and calc_done_i are each delayed by DATA_NUM-1 stages.
  - The aligned row and aligned valid/last therefore coincide in cycle t0+DATA_NUM-1, where t0 is the lane-0 input cycle.
  - DATA_NUM = 1: no stages.
- FIFO write: on the clock edge ending a cycle with aligned valid high, {row, last} is pushed.
- Latency: lane-0 input cycle t0 -> out_valid_o high in cycle t0+DATA_NUM, provided the FIFO was empty. The FIFO output is read combinationally from the head entry.
- Handshake:
  - Pop occurs when out_valid_o && out_ready_i.
  - out_valid_o/data_out hold stable while not popped.
  - Throughput is one row per cycle sustained.
- Simultaneous push and pop:
  - Allowed at any level, including full; level is unchanged.
  - When empty, the row is not bypassed; it is written and appears the next cycle.
- Full:
  - Condition: push with level == FIFO_DEPTH and no pop in the same cycle.
  - The row is dropped; overflow_o is set the next cycle and stays set until clear_i or reset.
  - If the dropped row carried last, no done_o is produced for that tile.
- Counter and done:
  - row_count_o increments by 1 on every pop, wrapping at 2^CNT_WIDTH.
  - done_o pulses in the cycle after a pop whose entry has last = 1.
- clear_i (synchronous, priority over everything except reset):
  - Empties the FIFO and zeroes the control delay chain, so in-flight rows are discarded.
  - Clears overflow_o and row_count_o, and suppresses done_o.
  - Input presented in the clear cycle is discarded.
- Reset mid-tile: all in-flight and buffered rows are lost. No done_o. Upstream must restart the tile.

Decomposition:
- Shared package (dsa_pkg): result lane width constant and the default array size DATA_NUM. Both must match the input skew stage.
- Sub-module sync_fifo:
  - Parameterised width/depth, push/pop, full/empty/level.
  - Async active-low reset on pointers only.
  - Instantiated with width DATA_WIDTH*DATA_NUM+1; the extra bit carries last.

Test Plan:
- Alignment, DATA_NUM=4, DATA_WIDTH=32: lane i of row r = 16*r+i, driven skewed (lane i at cycle t0+i), 3 rows with out_ready_i=1 -> rows {0,1,2,3},{16,17,18,19},{32,33,34,35}, first out_valid_o at t0+4, then back-to-back.
- Tile end: 5 rows, calc_done_i with row 4 -> out_last_o only on row 4; done_o pulses once, one cycle after its pop; row_count_o = 5.
- Backpressure and overflow, FIFO_DEPTH=4: out_ready_i=0, 6 consecutive rows -> fifo_level_o saturates at 4, overflow_o = 1; release ready -> exactly rows 0-3 emerge in order.
- Full push+pop: level 4, out_ready_i=1 with a new row each cycle for 8 cycles -> level stays 4, no overflow, all rows in order.
- clear_i mid-stream: 2 rows buffered plus 2 in the deskew chain, pulse clear_i -> out_valid_o = 0 next cycle, level 0, overflow_o and row_count_o = 0; later rows emerge normally.
- Async reset: assert rst_n low between clock edges with rows buffered -> outputs zero immediately; no stale row after release.
- DATA_NUM=1 -> latency 1 cycle, no skew.
